// File: rtl/pagerank_apply_if.sv
// Stream-in / rank-out bundle between the DMP serial stage and the PageRank apply block.
// The master drives the partial-vector stream and the slave returns the rank vector and status.
interface pagerank_apply_if #(
    parameter int NODES = 4
);
    logic [63:0] pagerank_serial_stream [NODES];
    logic        stream_start;
    logic        stream_done;
    logic [63:0] pagerank_out [NODES];
    logic        pagerank_valid;
    logic        nextIteration;
    logic        converged;
    logic [15:0] iteration_count;
    logic        stream_error;

    modport master (
        output pagerank_serial_stream, stream_start, stream_done,
        input  pagerank_out, pagerank_valid, nextIteration, converged,
               iteration_count, stream_error
    );

    modport slave (
        input  pagerank_serial_stream, stream_start, stream_done,
        output pagerank_out, pagerank_valid, nextIteration, converged,
               iteration_count, stream_error
    );
endinterface

// File: rtl/pagerank_apply.sv
// Sums per-thread partial rank vectors, applies damping plus the base term in Q32.32,
// and decides between launching another iteration and declaring convergence.
module pagerank_apply #(
    parameter int          NUM_HW_THREADS = 2,
    parameter int          NODES_IN_GRAPH = 4,
    parameter int          DAMPING_Q16    = 55705,
    parameter logic [63:0] BASE_TERM      = 64'h0000_0000_4CCC_CCCD,
    parameter logic [63:0] INIT_RANK      = 64'h0000_0000_4000_0000,
    parameter logic [63:0] EPSILON        = 64'h0000_0000_0001_0000,
    parameter int          MAX_ITER       = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pagerank_apply_if.slave       bus
);
    localparam logic [16:0] DAMP_C    = 17'(DAMPING_Q16);
    localparam logic [15:0] THREADS_C = 16'(NUM_HW_THREADS);
    localparam logic [31:0] MAX_IT_C  = 32'(MAX_ITER);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_SCALE   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [63:0] acc_r   [NODES_IN_GRAPH];
    logic [63:0] new_r   [NODES_IN_GRAPH];
    logic [63:0] prev_r  [NODES_IN_GRAPH];
    logic [63:0] out_r   [NODES_IN_GRAPH];
    logic [63:0] acc_sum_s [NODES_IN_GRAPH];
    logic [63:0] scaled_s  [NODES_IN_GRAPH];
    logic [15:0] beat_cnt_r, beat_inc_s;
    logic [15:0] iter_r, iter_inc_s;
    logic [63:0] max_diff_s;
    logic        stop_s;
    logic        valid_r, next_r, conv_r, err_r;

    function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[64]) begin
            return 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            return sum[63:0];
        end
    endfunction

    // The 81-bit product keeps one integer bit above 64 after the >>16; if set, the lane saturates.
    function automatic logic [63:0] scale_lane(input logic [63:0] a);
        logic [80:0] prod;
        logic [64:0] shifted;
        prod    = 81'(a) * 81'(DAMP_C);
        shifted = 65'(prod >> 16);
        if (shifted[64]) begin
            return 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            return sat_add64(shifted[63:0], BASE_TERM);
        end
    endfunction

    // Lane-wise datapath: running sum, scaled result and largest change versus the previous vector.
    always_comb begin
        logic [63:0] d;
        d          = 64'd0;
        max_diff_s = 64'd0;
        for (int i = 0; i < NODES_IN_GRAPH; i++) begin
            acc_sum_s[i] = sat_add64(acc_r[i], bus.pagerank_serial_stream[i]);
            scaled_s[i]  = scale_lane(acc_r[i]);
            if (new_r[i] >= prev_r[i]) begin
                d = new_r[i] - prev_r[i];
            end else begin
                d = prev_r[i] - new_r[i];
            end
            if (d > max_diff_s) begin
                max_diff_s = d;
            end else begin
                max_diff_s = max_diff_s;
            end
        end
    end

    // Saturating counters and the halt decision.
    always_comb begin
        beat_inc_s = (beat_cnt_r == 16'hFFFF) ? beat_cnt_r : beat_cnt_r + 16'd1;
        iter_inc_s = (iter_r == 16'hFFFF) ? iter_r : iter_r + 16'd1;
        stop_s     = (max_diff_s < EPSILON) || ({16'd0, iter_inc_s} >= MAX_IT_C);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.stream_start) begin
                    state_s = bus.stream_done ? ST_SCALE : ST_ACCUM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (bus.stream_done) begin
                    state_s = ST_SCALE;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_SCALE:   state_s = ST_COMPARE;
            ST_COMPARE: state_s = stop_s ? ST_DONE : ST_IDLE;
            ST_DONE:    state_s = ST_DONE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Accumulate, scale and commit registers; pulses default low every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                acc_r[i]  <= 64'd0;
                new_r[i]  <= 64'd0;
                prev_r[i] <= INIT_RANK;
                out_r[i]  <= INIT_RANK;
            end
            beat_cnt_r <= 16'd0;
            iter_r     <= 16'd0;
            valid_r    <= 1'b0;
            next_r     <= 1'b0;
            conv_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            next_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.stream_start) begin
                        acc_r      <= bus.pagerank_serial_stream;
                        beat_cnt_r <= 16'd1;
                    end
                end
                ST_ACCUM: begin
                    if (bus.stream_start) begin
                        acc_r      <= bus.pagerank_serial_stream;
                        beat_cnt_r <= 16'd1;
                    end else begin
                        acc_r      <= acc_sum_s;
                        beat_cnt_r <= beat_inc_s;
                    end
                end
                ST_SCALE: begin
                    new_r <= scaled_s;
                    if (beat_cnt_r != THREADS_C) begin
                        err_r <= 1'b1;
                    end
                end
                ST_COMPARE: begin
                    out_r   <= new_r;
                    prev_r  <= new_r;
                    valid_r <= 1'b1;
                    iter_r  <= iter_inc_s;
                    if (stop_s) begin
                        conv_r <= 1'b1;
                    end else begin
                        next_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    conv_r <= 1'b1;
                end
                default: begin
                    conv_r <= conv_r;
                end
            endcase
        end
    end

    assign bus.pagerank_out    = out_r;
    assign bus.pagerank_valid  = valid_r;
    assign bus.nextIteration   = next_r;
    assign bus.converged       = conv_r;
    assign bus.iteration_count = iter_r;
    assign bus.stream_error    = err_r;
endmodule

// File: tb/tb_pagerank_apply.sv
// Directed bench for pagerank_apply: three instances (base config, unity damping, MAX_ITER=2)
// share one stimulus stream; each scenario checks the instance that exercises it.
module tb_pagerank_apply;
    localparam logic [63:0] ONE  = 64'h1_0000_0000;
    localparam logic [63:0] BASE = 64'h2000_0000;
    localparam logic [63:0] INIT = 64'h4000_0000;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock;
    logic        reset_n;
    logic [63:0] stream [4];
    logic        st, dn;
    int          checks   = 0;
    int          failures = 0;
    int          vcount_a = 0;

    pagerank_apply_if #(.NODES(4)) ifa ();
    pagerank_apply_if #(.NODES(4)) ifb ();
    pagerank_apply_if #(.NODES(4)) ifc ();

    assign ifa.pagerank_serial_stream = stream;
    assign ifb.pagerank_serial_stream = stream;
    assign ifc.pagerank_serial_stream = stream;
    assign ifa.stream_start = st;
    assign ifb.stream_start = st;
    assign ifc.stream_start = st;
    assign ifa.stream_done  = dn;
    assign ifb.stream_done  = dn;
    assign ifc.stream_done  = dn;

    pagerank_apply #(.NUM_HW_THREADS(2), .NODES_IN_GRAPH(4), .DAMPING_Q16(32768),
        .BASE_TERM(BASE), .EPSILON(64'h1_0000), .MAX_ITER(32))
        dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa.slave));
    pagerank_apply #(.NUM_HW_THREADS(2), .NODES_IN_GRAPH(4), .DAMPING_Q16(65536),
        .BASE_TERM(BASE), .EPSILON(64'h1_0000), .MAX_ITER(32))
        dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb.slave));
    pagerank_apply #(.NUM_HW_THREADS(2), .NODES_IN_GRAPH(4), .DAMPING_Q16(32768),
        .BASE_TERM(BASE), .EPSILON(64'd0), .MAX_ITER(2))
        dut_c (.clock(clock), .reset_n(reset_n), .bus(ifc.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ifa.pagerank_valid === 1'b1) vcount_a++;
    end

    typedef struct {
        logic [3:0][63:0] b0;
        logic [3:0][63:0] b1;
        logic [3:0][63:0] exp_out;
        logic             exp_next;
        logic             exp_conv;
        logic [15:0]      exp_iter;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [3:0][63:0] b, input logic s, input logic d);
        for (int i = 0; i < 4; i++) stream[i] = b[i];
        st = s;
        dn = d;
        @(negedge clock);
    endtask

    task automatic idle_in();
        for (int i = 0; i < 4; i++) stream[i] = 64'd0;
        st = 1'b0;
        dn = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Two-beat stream; returns at the cycle the result becomes visible (3 cycles after done beat).
    task automatic send_two(input logic [3:0][63:0] b0, input logic [3:0][63:0] b1);
        beat(b0, 1'b1, 1'b0);
        beat(b1, 1'b0, 1'b1);
        idle_in();
        @(negedge clock);
        chk("valid_early", ifa.pagerank_valid, 1'b0);
        @(negedge clock);
    endtask

    vec_t             tbl [2];
    logic [3:0][63:0] s1_b0, s1_b1, s1_exp, z, b4;
    int               vsnap;

    initial begin
        reset_n = 1'b0;
        idle_in();
        z      = '0;
        s1_b0  = {64'd0, 64'd0, ONE, ONE};
        s1_b1  = {2 * ONE, 64'd0, 64'd0, ONE};
        s1_exp = {64'h1_2000_0000, 64'h2000_0000, 64'hA000_0000, 64'h1_2000_0000};
        b4     = {64'd0, 64'd0, 64'd0, 4 * ONE};
        tbl[0] = '{b0: s1_b0, b1: s1_b1, exp_out: s1_exp, exp_next: 1'b1, exp_conv: 1'b0, exp_iter: 16'd1};
        tbl[1] = '{b0: s1_b0, b1: s1_b1, exp_out: s1_exp, exp_next: 1'b0, exp_conv: 1'b1, exp_iter: 16'd2};

        do_reset();
        for (int i = 0; i < 4; i++) chk("reset_out", ifa.pagerank_out[i], INIT);
        chk("reset_valid", ifa.pagerank_valid, 1'b0);
        chk("reset_next", ifa.nextIteration, 1'b0);
        chk("reset_conv", ifa.converged, 1'b0);
        chk("reset_iter", ifa.iteration_count, 16'd0);
        chk("reset_err", ifa.stream_error, 1'b0);

        // Scenarios 1 and 2: basic iteration then convergence on an identical stream
        for (int r = 0; r < 2; r++) begin
            send_two(tbl[r].b0, tbl[r].b1);
            for (int i = 0; i < 4; i++) chk("tbl_out", ifa.pagerank_out[i], tbl[r].exp_out[i]);
            chk("tbl_valid", ifa.pagerank_valid, 1'b1);
            chk("tbl_next", ifa.nextIteration, tbl[r].exp_next);
            chk("tbl_conv", ifa.converged, tbl[r].exp_conv);
            chk("tbl_iter", ifa.iteration_count, tbl[r].exp_iter);
            chk("tbl_err", ifa.stream_error, 1'b0);
            @(negedge clock);
            chk("tbl_valid_pulse", ifa.pagerank_valid, 1'b0);
            chk("tbl_next_pulse", ifa.nextIteration, 1'b0);
        end

        // Converged: a further stream is ignored
        vsnap = vcount_a;
        beat(b4, 1'b1, 1'b0);
        beat(b4, 1'b0, 1'b1);
        idle_in();
        repeat (4) @(negedge clock);
        chk("done_out0", ifa.pagerank_out[0], 64'h1_2000_0000);
        chk("done_iter", ifa.iteration_count, 16'd2);
        chk("done_conv", ifa.converged, 1'b1);
        chk("done_novalid", 64'(vcount_a - vsnap), 64'd0);

        // Scenario 3: single start+done beat, short count and saturation
        do_reset();
        beat({64'd0, 64'd0, 64'd0, ALL1}, 1'b1, 1'b1);
        idle_in();
        repeat (2) @(negedge clock);
        chk("sat_err_b", ifb.stream_error, 1'b1);
        chk("sat_valid_b", ifb.pagerank_valid, 1'b1);
        chk("sat_lane0_b", ifb.pagerank_out[0], ALL1);
        chk("sat_lane1_b", ifb.pagerank_out[1], BASE);
        chk("sat_err_a", ifa.stream_error, 1'b1);
        chk("half_lane0_a", ifa.pagerank_out[0], 64'h8000_0000_1FFF_FFFF);

        // Scenario 4: restart mid-stream discards the first partial sum
        do_reset();
        beat(b4, 1'b1, 1'b0);
        send_two(s1_b0, s1_b1);
        for (int i = 0; i < 4; i++) chk("restart_out", ifa.pagerank_out[i], s1_exp[i]);
        chk("restart_err", ifa.stream_error, 1'b0);
        chk("restart_iter", ifa.iteration_count, 16'd1);
        chk("restart_next", ifa.nextIteration, 1'b1);

        // Scenario 5: iteration cap with EPSILON=0
        do_reset();
        send_two(s1_b0, s1_b1);
        chk("cap_next1", ifc.nextIteration, 1'b1);
        chk("cap_conv1", ifc.converged, 1'b0);
        chk("cap_iter1", ifc.iteration_count, 16'd1);
        @(negedge clock);
        send_two({64'd0, 64'd0, 64'd0, 2 * ONE}, {64'd0, 64'd0, 64'd0, 2 * ONE});
        chk("cap_next2", ifc.nextIteration, 1'b0);
        chk("cap_conv2", ifc.converged, 1'b1);
        chk("cap_iter2", ifc.iteration_count, 16'd2);
        chk("cap_out0", ifc.pagerank_out[0], 64'h2_2000_0000);

        // Scenario 6: reset while in SCALE
        do_reset();
        vsnap = vcount_a;
        beat(s1_b0, 1'b1, 1'b0);
        beat(s1_b1, 1'b0, 1'b1);
        idle_in();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_novalid", 64'(vcount_a - vsnap), 64'd0);
        for (int i = 0; i < 4; i++) chk("rst_out", ifa.pagerank_out[i], INIT);
        chk("rst_iter", ifa.iteration_count, 16'd0);
        send_two(s1_b0, s1_b1);
        chk("rst_idle_out0", ifa.pagerank_out[0], s1_exp[0]);
        chk("rst_idle_iter", ifa.iteration_count, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
